// File: rtl/decrypt_seq_ctrl_pkg.sv
// rtl/decrypt_seq_ctrl_pkg.sv - shared decryption sequencer types and constants
package decrypt_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FFT  = 2'd1,
    ST_SYND = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam logic [1:0] OP_SYND = 2'b01;
  localparam logic [1:0] OP_RENC = 2'b10;

  localparam int unsigned TMO_W_DEFAULT = 20;

  function automatic logic op_valid(input logic [1:0] op);
    return (op == OP_SYND) || (op == OP_RENC);
  endfunction

endpackage

// File: rtl/decrypt_seq_ctrl_edge_rise.sv
// rtl/decrypt_seq_ctrl_edge_rise.sv - registered rising-edge detector
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= d_i;
    end
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/decrypt_seq_ctrl.sv
// rtl/decrypt_seq_ctrl.sv - sequences one add_FFT + doubled_syndrome decode pass
// and arbitrates the P read port between the syndrome and re-encrypt requesters.
module decrypt_seq_ctrl
  import decrypt_seq_ctrl_pkg::*;
#(
  parameter int unsigned m     = 13,
  parameter int unsigned t     = 119,
  parameter int unsigned TMO_W = TMO_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [31:0]  cycles,
  output logic         fft_start,
  input  logic         fft_done,
  output logic         synd_start,
  output logic [1:0]   synd_op,
  input  logic         synd_done,
  input  logic         synd_P_rd_en,
  input  logic [m-1:0] synd_P_rd_addr,
  input  logic         renc_P_rd_en,
  input  logic [m-1:0] renc_P_rd_addr,
  output logic         P_rd_en,
  output logic [m-1:0] P_rd_addr
);

  // Watchdog fires on the edge where its count would reach all-ones.
  localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  // t only shapes widths of neighbouring blocks; kept for a uniform parameter set.
  logic unused_cfg;
  assign unused_cfg = (t == 0);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       cycles_q, cycles_d;
  logic [TMO_W-1:0]  wd_q, wd_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              fft_start_q, fft_start_d;
  logic              synd_start_q, synd_start_d;
  logic              fft_rise, synd_rise;

  edge_rise u_fft_rise (
    .clk    (clk),
    .rst    (rst),
    .d_i    (fft_done),
    .rise_o (fft_rise)
  );

  edge_rise u_synd_rise (
    .clk    (clk),
    .rst    (rst),
    .d_i    (synd_done),
    .rise_o (synd_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= 2'b00;
      cnt_q        <= '0;
      cycles_q     <= '0;
      wd_q         <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      fft_start_q  <= 1'b0;
      synd_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      cycles_q     <= cycles_d;
      wd_q         <= wd_d;
      err_q        <= err_d;
      done_q       <= done_d;
      fft_start_q  <= fft_start_d;
      synd_start_q <= synd_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    cycles_d     = cycles_q;
    wd_d         = wd_q;
    err_d        = err_q;
    done_d       = 1'b0;
    fft_start_d  = 1'b0;
    synd_start_d = 1'b0;

    if (state_q != ST_IDLE && cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        // The accepting cycle counts as cycle 1, so cycles equals start-to-done latency.
        if (start && op_valid(op_in)) begin
          state_d     = ST_FFT;
          op_d        = op_in;
          cnt_d       = 32'd1;
          wd_d        = '0;
          err_d       = 1'b0;
          fft_start_d = 1'b1;
        end
      end
      ST_FFT: begin
        if (fft_rise) begin
          state_d      = ST_SYND;
          synd_start_d = 1'b1;
          wd_d         = '0;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_FIN;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + TMO_W'(1);
        end
      end
      ST_SYND: begin
        if (synd_rise) begin
          state_d = ST_FIN;
          wd_d    = '0;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_FIN;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + TMO_W'(1);
        end
      end
      ST_FIN: begin
        state_d  = ST_IDLE;
        done_d   = 1'b1;
        cycles_d = cnt_d;
        wd_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign cycles     = cycles_q;
  assign fft_start  = fft_start_q;
  assign synd_start = synd_start_q;
  assign synd_op    = op_q;

  // Syndrome engine owns P only for a cipher-syndrome pass in SYND; the loser is dropped.
  always_comb begin
    P_rd_en   = renc_P_rd_en;
    P_rd_addr = renc_P_rd_addr;
    if (busy && state_q == ST_SYND && op_q == OP_SYND) begin
      P_rd_en   = synd_P_rd_en;
      P_rd_addr = synd_P_rd_addr;
    end
  end

endmodule
